tick_gen: RTL and testbench

- Multi-channel, runtime-programmable tick (clock-enable) generator. It replaces the fixed compile-time integer dividers for the peripheral, RTC and UART bit clocks.
- Each channel is a phase accumulator: acc += INC, with a wrap at MOD. The tick rate is clock_freq*INC/MOD, so integer dividers (INC=1) and fractional rates such as a baud clock both work without cumulative drift.
- Sits beside the clock source and feeds single-cycle enables to the UART, CLINT/RTC and peripheral-bus logic.

---
 rtl/tick_gen.sv | 96 +++++++++
 tb/tb_tick_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator: each channel is a phase accumulator
// (acc += INC, wrap at MOD) producing a registered single-cycle clock enable.
module tick_gen #(
    parameter int               NCH     = 3,
    parameter int               W       = 32,
    parameter int               CW      = (NCH > 1) ? $clog2(NCH) : 1,
    parameter logic [NCH*W-1:0] DEF_INC = {32'd115200, 32'd1, 32'd1},
    parameter logic [NCH*W-1:0] DEF_MOD = {32'd1000000000, 32'd1000, 32'd5}
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [NCH-1:0] en,
    input  logic           cfg_valid,
    input  logic [CW-1:0]  cfg_chan,
    input  logic [W-1:0]   cfg_inc,
    input  logic [W-1:0]   cfg_mod,
    output logic           cfg_ready,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] cfg_err
);

    function automatic logic illegal(input logic [W-1:0] inc, input logic [W-1:0] mod);
        return (inc == '0) || (mod == '0) || (inc > mod);
    endfunction

    logic cfg_ready_q;
    logic cfg_ready_d;
    logic wr_en;

    assign cfg_ready_d = 1'b1;
    assign wr_en       = cfg_valid & cfg_ready_q;
    assign cfg_ready   = cfg_ready_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_ready_q <= 1'b0;
        end else begin
            cfg_ready_q <= cfg_ready_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [W-1:0] acc_q, acc_d;
            logic [W-1:0] inc_q, inc_d;
            logic [W-1:0] mod_q, mod_d;
            logic         tick_q, tick_d;
            logic         err_q, err_d;
            logic [W:0]   sum;

            always_comb begin
                acc_d  = acc_q;
                inc_d  = inc_q;
                mod_d  = mod_q;
                err_d  = err_q;
                tick_d = 1'b0;
                // One extra bit so acc+inc can never wrap before the MOD compare
                sum    = {1'b0, acc_q} + {1'b0, inc_q};
                if (wr_en && (cfg_chan == CW'(gi))) begin
                    inc_d = cfg_inc;
                    mod_d = cfg_mod;
                    acc_d = '0;
                    err_d = illegal(cfg_inc, cfg_mod);
                end else if (en[gi] && !err_q) begin
                    if (sum >= {1'b0, mod_q}) begin
                        acc_d  = W'(sum - {1'b0, mod_q});
                        tick_d = 1'b1;
                    end else begin
                        acc_d  = sum[W-1:0];
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    acc_q  <= '0;
                    inc_q  <= DEF_INC[gi*W +: W];
                    mod_q  <= DEF_MOD[gi*W +: W];
                    tick_q <= 1'b0;
                    err_q  <= illegal(DEF_INC[gi*W +: W], DEF_MOD[gi*W +: W]);
                end else begin
                    acc_q  <= acc_d;
                    inc_q  <= inc_d;
                    mod_q  <= mod_d;
                    tick_q <= tick_d;
                    err_q  <= err_d;
                end
            end

            assign tick[gi]    = tick_q;
            assign cfg_err[gi] = err_q;
        end
    endgenerate

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: a counting model (ticks = floor(n*INC/MOD) over n enabled
// cycles since the last configuration) checked every cycle, plus directed scenarios.
module tb_tick_gen;
    localparam int NCH = 3;
    localparam int W   = 32;
    localparam int CW  = 2;

    logic           clock;
    logic           reset;
    logic [NCH-1:0] en;
    logic           cfg_valid;
    logic [CW-1:0]  cfg_chan;
    logic [W-1:0]   cfg_inc;
    logic [W-1:0]   cfg_mod;
    logic           cfg_ready;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] cfg_err;

    tick_gen dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_chan  (cfg_chan),
        .cfg_inc   (cfg_inc),
        .cfg_mod   (cfg_mod),
        .cfg_ready (cfg_ready),
        .tick      (tick),
        .cfg_err   (cfg_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: enabled-cycle count since last configuration, plus the config itself
    longint         m_n   [NCH];
    longint         m_inc [NCH];
    longint         m_mod [NCH];
    logic [NCH-1:0] m_tick;
    logic [NCH-1:0] m_err;
    logic           m_ready;
    bit             m_valid = 0;
    longint         def_inc [NCH] = '{1, 1, 115200};
    longint         def_mod [NCH] = '{5, 1000, 1000000000};

    function automatic logic ill(input longint inc, input longint mod);
        return (inc == 0) || (mod == 0) || (inc > mod);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_valid = 1;
            m_ready = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_n[i]    = 0;
                m_inc[i]  = def_inc[i];
                m_mod[i]  = def_mod[i];
                m_tick[i] = 1'b0;
                m_err[i]  = ill(def_inc[i], def_mod[i]);
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_valid && m_ready && (int'(cfg_chan) == i)) begin
                    m_inc[i]  = longint'(cfg_inc);
                    m_mod[i]  = longint'(cfg_mod);
                    m_n[i]    = 0;
                    m_tick[i] = 1'b0;
                    m_err[i]  = ill(m_inc[i], m_mod[i]);
                end else if (!en[i] || m_err[i]) begin
                    m_tick[i] = 1'b0;
                end else begin
                    m_n[i]++;
                    m_tick[i] = ((m_n[i] * m_inc[i]) / m_mod[i]) !=
                                (((m_n[i] - 1) * m_inc[i]) / m_mod[i]);
                end
            end
            m_ready = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("cmp_tick", 64'(tick), 64'(m_tick));
            check("cmp_err", 64'(cfg_err), 64'(m_err));
            check("cmp_ready", 64'(cfg_ready), 64'(m_ready));
        end
    end

    task automatic cfg_write(input int ch, input int inc, input int mod);
        cfg_valid = 1'b1;
        cfg_chan  = CW'(ch);
        cfg_inc   = W'(inc);
        cfg_mod   = W'(mod);
        @(negedge clock);
        cfg_valid = 1'b0;
    endtask

    task automatic run_until_tick(input int ch, input int maxe, output int edges);
        edges = -1;
        for (int k = 1; k <= maxe; k++) begin
            @(negedge clock);
            if (tick[ch]) begin
                edges = k;
                break;
            end
        end
    endtask

    int pos[$];
    int e;
    logic [1:0] other;

    initial begin
        reset = 1'b1; en = '0; cfg_valid = 1'b0; cfg_chan = '0; cfg_inc = '0; cfg_mod = '0;
        @(negedge clock);
        check("rst_ready", 64'(cfg_ready), 0);
        check("rst_tick", 64'(tick), 0);
        check("rst_err", 64'(cfg_err), 0);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_rst", 64'(cfg_ready), 1);

        // ch0 default divide-by-5
        en = 3'b001; pos.delete(); other = '0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            if (tick[0]) pos.push_back(k);
            other |= tick[2:1];
        end
        check("t1_count", 64'(pos.size()), 3);
        if (pos.size() == 3) begin
            check("t1_pos0", 64'(pos[0]), 5);
            check("t1_pos1", 64'(pos[1]), 10);
            check("t1_pos2", 64'(pos[2]), 15);
        end
        check("t1_others", 64'(other), 0);

        // ch1 default divide-by-1000
        en = 3'b010; pos.delete();
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clock);
            if (tick[1]) pos.push_back(k);
        end
        check("t2_count", 64'(pos.size()), 3);
        if (pos.size() == 3) begin
            check("t2_pos0", 64'(pos[0]), 1000);
            check("t2_pos1", 64'(pos[1]), 2000);
            check("t2_pos2", 64'(pos[2]), 3000);
        end

        // ch2 fractional 3/10
        en = 3'b000;
        cfg_write(2, 3, 10);
        en = 3'b100; pos.delete();
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (tick[2]) pos.push_back(k);
        end
        check("t3_count", 64'(pos.size()), 9);
        if (pos.size() > 0) check("t3_first", 64'(pos[0]), 4);
        for (int i = 1; i < pos.size(); i++)
            check("t3_spacing", 64'((pos[i] - pos[i-1] == 3) || (pos[i] - pos[i-1] == 4)), 1);

        // illegal configurations
        en = 3'b001;
        cfg_write(0, 0, 5);
        check("t4_err_inc0", 64'(cfg_err[0]), 1);
        run_until_tick(0, 10, e);
        check("t4_no_tick", 64'(e), -64'sd1);
        cfg_write(0, 6, 5);
        check("t4_err_inc_gt_mod", 64'(cfg_err[0]), 1);
        cfg_write(0, 2, 2);
        check("t4_err_clear", 64'(cfg_err[0]), 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            check("t4_tick_every", 64'(tick[0]), 1);
        end

        // write on the edge a tick is due
        cfg_write(0, 1, 5);
        repeat (4) @(negedge clock);
        cfg_write(0, 1, 5);
        check("t5_dropped_tick", 64'(tick[0]), 0);
        run_until_tick(0, 20, e);
        check("t5_next_tick", 64'(e), 5);
        cfg_write(3, 0, 0);
        check("t5_chan3_err", 64'(cfg_err), 0);
        run_until_tick(0, 20, e);
        check("t5_chan3_phase", 64'(e), 4);

        // enable gap preserves phase
        cfg_write(0, 1, 5);
        repeat (3) @(negedge clock);
        en = 3'b000;
        run_until_tick(0, 7, e);
        check("t6_hold_no_tick", 64'(e), -64'sd1);
        en = 3'b001;
        run_until_tick(0, 10, e);
        check("t6_resume", 64'(e), 2);

        // reset mid-run restores defaults
        en = 3'b111;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t6_rst_tick", 64'(tick), 0);
        check("t6_rst_ready", 64'(cfg_ready), 0);
        check("t6_rst_err", 64'(cfg_err), 0);
        reset = 1'b0;
        en = 3'b101;
        @(negedge clock);
        check("t6_ready_again", 64'(cfg_ready), 1);
        run_until_tick(0, 10, e);
        check("t6_def_ch0", 64'(e), 4);
        run_until_tick(2, 9000, e);
        check("t6_def_baud", 64'(e), 8676);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
